// File: rtl/demorgan_pipe.sv
// Two-stage valid/ready logic unit: computes NOR/NAND/OR/AND in direct and De Morgan
// form per lane, returns the direct result and flags any lane where the two disagree.
module demorgan_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             inject,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] e,
  output logic             eq,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic             r_v1;
  logic             r_v2;
  logic [WIDTH-1:0] r_a1;
  logic [WIDTH-1:0] r_b1;
  logic [1:0]       r_mode1;
  logic             r_inject1;
  logic [WIDTH-1:0] r_e2;
  logic             r_eq2;
  logic [CNT_W-1:0] r_txnCnt;
  logic [CNT_W-1:0] r_errCnt;

  logic             w_s2Free;
  logic             w_s1Advance;
  logic             w_inFire;
  logic             w_outFire;
  logic [WIDTH-1:0] w_direct;
  logic [WIDTH-1:0] w_deMorgan;
  logic [WIDTH-1:0] w_injMask;

  // in_ready depends on out_ready and the stage valids only, never on in_valid.
  assign w_s2Free    = ~r_v2 | out_ready;
  assign w_s1Advance = r_v1 & w_s2Free;
  assign in_ready    = ~r_v1 | w_s1Advance;
  assign w_inFire    = in_valid & in_ready;
  assign w_outFire   = r_v2 & out_ready;

  always_comb begin
    w_direct   = '0;
    w_deMorgan = '0;
    case (r_mode1)
      2'b00: begin
        w_direct   = ~(r_a1 | r_b1);
        w_deMorgan = ~r_a1 & ~r_b1;
      end
      2'b01: begin
        w_direct   = ~(r_a1 & r_b1);
        w_deMorgan = ~r_a1 | ~r_b1;
      end
      2'b10: begin
        w_direct   = r_a1 | r_b1;
        w_deMorgan = ~(~r_a1 & ~r_b1);
      end
      default: begin
        w_direct   = r_a1 & r_b1;
        w_deMorgan = ~(~r_a1 | ~r_b1);
      end
    endcase
    w_injMask    = '0;
    w_injMask[0] = r_inject1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_e2     <= '0;
      r_eq2    <= 1'b1;
      r_txnCnt <= '0;
      r_errCnt <= '0;
    end else begin
      if (w_inFire) begin
        r_a1      <= a;
        r_b1      <= b;
        r_mode1   <= mode;
        r_inject1 <= inject;
      end
      r_v1 <= w_inFire | (r_v1 & ~w_s1Advance);

      if (w_s1Advance) begin
        r_e2  <= w_direct;
        r_eq2 <= (w_direct == (w_deMorgan ^ w_injMask));
      end
      r_v2 <= w_s1Advance | (r_v2 & ~out_ready);

      // Clear wins over a same-cycle delivery; counters stick at all-ones.
      if (clr) begin
        r_txnCnt <= '0;
        r_errCnt <= '0;
      end else if (w_outFire) begin
        if (r_txnCnt != '1) r_txnCnt <= r_txnCnt + CNT_W'(1);
        if (!r_eq2 && (r_errCnt != '1)) r_errCnt <= r_errCnt + CNT_W'(1);
      end
    end
  end

  assign out_valid = r_v2;
  assign e         = r_e2;
  assign eq        = r_eq2;
  assign txn_cnt   = r_txnCnt;
  assign err_cnt   = r_errCnt;

endmodule

// File: tb/tb_demorgan_pipe.sv
// Directed-vector and scoreboard bench for demorgan_pipe; a second instance with
// 2-bit counters shares the stimulus to exercise counter saturation.
module tb_demorgan_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [1:0] mode = '0;
  logic       inject = 1'b0;
  logic       clr = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready, out_valid, eq;
  logic [7:0] e, txn_cnt, err_cnt;
  logic       in_ready2, out_valid2, eq2;
  logic [7:0] e2;
  logic [1:0] txn2, err2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] e;
    logic       eq;
  } exp_t;
  exp_t q[$];
  int mTxn = 0, mErr = 0, mTxn2 = 0, mErr2 = 0;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       inj;
    logic [7:0] expE;
    logic       expEq;
    int         expTxn;
    int         expErr;
  } vec_t;
  vec_t vecs[9];

  demorgan_pipe #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .inject(inject), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .e(e), .eq(eq),
    .txn_cnt(txn_cnt), .err_cnt(err_cnt)
  );

  demorgan_pipe #(.WIDTH(8), .CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .mode(mode), .inject(inject), .clr(clr),
    .out_valid(out_valid2), .out_ready(out_ready), .e(e2), .eq(eq2),
    .txn_cnt(txn2), .err_cnt(err2)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] refDirect(input logic [1:0] m, input logic [7:0] x,
                                           input logic [7:0] y);
    case (m)
      2'b00:   return ~(x | y);
      2'b01:   return ~(x & y);
      2'b10:   return x | y;
      default: return x & y;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction scoreboard: queue filled on input handshakes, drained on output handshakes.
  always @(negedge clk) begin
    checkOutput("sb_txn", txn_cnt, mTxn);
    checkOutput("sb_err", err_cnt, mErr);
    checkOutput("sb_txn2", txn2, mTxn2);
    checkOutput("sb_err2", err2, mErr2);
    if (!rst && q.size() == 0) begin
      checkOutput("sb_empty_valid", {out_valid, out_valid2}, 2'b00);
      checkOutput("sb_empty_ready", {in_ready, in_ready2}, 2'b11);
    end
    if (rst) begin
      q.delete();
      mTxn = 0; mErr = 0; mTxn2 = 0; mErr2 = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_extra_beat: got e=%0h with no beat outstanding", e);
        end else begin
          checkOutput("sb_e", e, q[0].e);
          checkOutput("sb_eq", eq, q[0].eq);
          checkOutput("sb_e2", e2, q[0].e);
          checkOutput("sb_eq2", eq2, q[0].eq);
          if (mTxn < 255) mTxn++;
          if (mTxn2 < 3) mTxn2++;
          if (!q[0].eq && mErr < 255) mErr++;
          if (!q[0].eq && mErr2 < 3) mErr2++;
          void'(q.pop_front());
        end
      end
      if (clr) begin
        mTxn = 0; mErr = 0; mTxn2 = 0; mErr2 = 0;
      end
      if (in_valid && in_ready) q.push_back('{refDirect(mode, a, b), !inject});
    end
  end

  task automatic applyStimulus(input vec_t v, input int idx);
    mode = v.mode; a = v.a; b = v.b; inject = v.inj; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); mode = 2'($urandom); inject = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("vec%0d_early_valid", idx), out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput($sformatf("vec%0d_valid", idx), out_valid, 1'b1);
    checkOutput($sformatf("vec%0d_e", idx), e, v.expE);
    checkOutput($sformatf("vec%0d_eq", idx), eq, v.expEq);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput($sformatf("vec%0d_drained", idx), out_valid, 1'b0);
    checkOutput($sformatf("vec%0d_txn", idx), txn_cnt, v.expTxn);
    checkOutput($sformatf("vec%0d_err", idx), err_cnt, v.expErr);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] bpVals[5];
    logic [7:0] gotE[5];
    logic [7:0] heldE;
    int         got, idx;
    logic       fire;

    vecs[0] = '{2'b00, 8'hF0, 8'h0F, 1'b0, 8'h00, 1'b1, 1, 0};
    vecs[1] = '{2'b01, 8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b1, 2, 0};
    vecs[2] = '{2'b10, 8'hF0, 8'h0C, 1'b0, 8'hFC, 1'b1, 3, 0};
    vecs[3] = '{2'b11, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b1, 4, 0};
    vecs[4] = '{2'b00, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 5, 1};
    vecs[5] = '{2'b00, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 6, 1};
    vecs[6] = '{2'b01, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b1, 7, 1};
    vecs[7] = '{2'b11, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b0, 8, 2};
    vecs[8] = '{2'b10, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 9, 2};
    bpVals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_e", e, 8'h00);
    checkOutput("rst_eq", eq, 1'b1);
    checkOutput("rst_txn", txn_cnt, 0);
    checkOutput("rst_err", err_cnt, 0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);

    $display("[TB] backpressure");
    got = 0; idx = 0;
    out_ready = 1'b0; mode = 2'b11; a = 8'hFF; b = bpVals[0]; in_valid = 1'b1;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        gotE[got] = e;
        got++;
      end
      fire = in_valid && in_ready;
      if (c == 2) begin
        checkOutput("bp_in_ready_low", in_ready, 1'b0);
        heldE = e;
      end
      if (c == 3) begin
        checkOutput("bp_e_held", e, heldE);
        checkOutput("bp_e_first", e, 8'h11);
        checkOutput("bp_eq_held", eq, 1'b1);
        checkOutput("bp_in_ready_still_low", in_ready, 1'b0);
      end
      @(posedge clk);
      if (fire) idx++;
      #1;
      out_ready = (c + 1 >= 4);
      in_valid  = (idx < 5);
      b         = (idx < 5) ? bpVals[idx] : 8'($urandom);
      a         = (idx < 5) ? 8'hFF : 8'($urandom);
    end
    in_valid = 1'b0;
    checkOutput("bp_count", got, 5);
    for (int i = 0; i < 5; i++)
      if (i < got) checkOutput($sformatf("bp_order%0d", i), gotE[i], bpVals[i]);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] saturation and clear");
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    checkOutput("clr_txn", txn_cnt, 0);
    checkOutput("clr_err", err_cnt, 0);
    checkOutput("clr_txn2", txn2, 0);
    checkOutput("clr_err2", err2, 0);
    @(posedge clk); #1;
    mode = 2'b00; a = 8'h00; b = 8'h00; inject = 1'b1; in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b0; inject = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("sat_txn2", txn2, 3);
    checkOutput("sat_err2", err2, 3);
    checkOutput("sat_txn8", txn_cnt, 5);
    checkOutput("sat_err8", err_cnt, 5);
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 clr = 1'b1;
    @(negedge clk);
    checkOutput("clrhs_pre_valid", out_valid, 1'b1);
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    checkOutput("clrhs_valid", out_valid, 1'b0);
    checkOutput("clrhs_txn", txn_cnt, 0);
    checkOutput("clrhs_err", err_cnt, 0);
    checkOutput("clrhs_txn2", txn2, 0);
    checkOutput("clrhs_err2", err2, 0);
    @(posedge clk); #1;

    $display("[TB] reset mid-operation");
    out_ready = 1'b0; mode = 2'b10; a = 8'h12; b = 8'h34; in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_full_in_ready", in_ready, 1'b0);
    checkOutput("mid_full_valid", out_valid, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_valid", out_valid, 1'b0);
    checkOutput("mid_rst_e", e, 8'h00);
    checkOutput("mid_rst_eq", eq, 1'b1);
    checkOutput("mid_rst_txn", txn_cnt, 0);
    checkOutput("mid_rst_err", err_cnt, 0);
    checkOutput("mid_rst_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("mid_no_stale", out_valid, 1'b0);
    end
    @(posedge clk); #1;

    $display("[TB] random regression");
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 63) == 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      mode      = 2'($urandom);
      inject    = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("drain_queue_empty", q.size(), 0);
    checkOutput("drain_out_valid", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
